// File: rtl/fib_pkg.sv
// fib_pkg: shared types and constants for the bit-serial Fibonacci generator.
//   fib_state_e  - controller state encoding (IDLE, ADD, DONE, HALT)
//   FIB_DEF_*    - default width, index width and seed values
//   fib_cnt_w()  - bit-counter width for a given term width
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } fib_state_e;

  localparam int unsigned FIB_DEF_WIDTH  = 16;
  localparam int unsigned FIB_DEF_IDXW   = 8;
  localparam int unsigned FIB_DEF_SEED_A = 0;
  localparam int unsigned FIB_DEF_SEED_B = 1;

  // Counter only has to address bits 0..WIDTH-1; keep it at least 1 bit wide.
  function automatic int unsigned fib_cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned FIB_CNT_W = fib_cnt_w(FIB_DEF_WIDTH);

endpackage

// File: rtl/fib_bit_cell.sv
// fib_bit_cell: single full-adder cell with a registered carry, the one
// arithmetic element shared by every bit position of the serial adder.
//   clk, reset  - rising-edge clock, asynchronous active-low reset
//   a, b        - operand bits for the current bit position
//   carry_clr   - synchronous clear of the carry flop (wins over en)
//   en          - advance: capture the carry-out of this bit
//   s           - combinational sum bit a ^ b ^ carry
//   carry       - registered carry into the current bit position
module fib_bit_cell (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic carry_clr,
  input  logic en,
  output logic s,
  output logic carry
);

  assign s = a ^ b ^ carry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
    end else if (carry_clr) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= (a & b) | (a & carry) | (b & carry);
    end
  end

endmodule

// File: rtl/fib_serial_gen.sv
// fib_serial_gen: bit-serial Fibonacci term generator. Holds the previous
// term A and current term B; each accepted step adds A+B LSB-first through
// one fib_bit_cell over WIDTH cycles, then shifts the pair (A<=B, B<=sum).
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   clear     - synchronous restart to seeds (beats everything but reset)
//   step      - request next term, sampled only in IDLE
//   busy      - high while in ADD or DONE
//   valid     - one-cycle pulse when term/index have just updated
//   term      - current term B (never shows a partial sum)
//   index     - sequence index of term, 1 after reset
//   overflow  - sticky carry-out of any addition
//   halted    - SATURATE=1 only: overflow seen, steps refused
//   state_dbg - current controller state (fib_state_e encoding)
//
// Handshake: step is a request, not a held level. It is taken only on an
// edge where the controller is IDLE (and clear is low); requests arriving
// while busy or halted are dropped, never queued. Completion is signalled by
// a single-cycle valid pulse coinciding with the first cycle that term and
// index show the new values: step accepted at edge 0 -> valid after edge
// WIDTH+1, next step can be accepted at edge WIDTH+2.
module fib_serial_gen
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH    = FIB_DEF_WIDTH,
  parameter int unsigned SEED_A   = FIB_DEF_SEED_A,
  parameter int unsigned SEED_B   = FIB_DEF_SEED_B,
  parameter int unsigned IDXW     = FIB_DEF_IDXW,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] term,
  output logic [IDXW-1:0]  index,
  output logic             overflow,
  output logic             halted,
  output logic [1:0]       state_dbg
);

  localparam int unsigned     CNTW      = fib_cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] SEED_A_V = WIDTH'(SEED_A);
  localparam logic [WIDTH-1:0] SEED_B_V = WIDTH'(SEED_B);
  localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);

  fib_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic [CNTW-1:0]  cnt_q;
  logic [IDXW-1:0]  index_q;
  logic             ovf_q;
  logic             halted_q;
  logic             busy_q;
  logic             valid_q;

  logic sum_bit;
  logic carry_q;
  logic cell_clr;
  logic cell_en;

  // A and B stay parallel during the add; the counter selects the bit, so
  // term (a direct view of B) cannot glitch mid-computation.
  assign cell_clr = clear | ((state_q == ST_IDLE) & step);
  assign cell_en  = (state_q == ST_ADD) & ~clear;

  fib_bit_cell u_cell (
    .clk       (clk),
    .reset     (reset),
    .a         (a_q[cnt_q]),
    .b         (b_q[cnt_q]),
    .carry_clr (cell_clr),
    .en        (cell_en),
    .s         (sum_bit),
    .carry     (carry_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      a_q      <= SEED_A_V;
      b_q      <= SEED_B_V;
      s_q      <= '0;
      cnt_q    <= '0;
      index_q  <= IDX_ONE;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      a_q      <= SEED_A_V;
      b_q      <= SEED_B_V;
      s_q      <= '0;
      cnt_q    <= '0;
      index_q  <= IDX_ONE;
      ovf_q    <= 1'b0;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (step) begin
            state_q <= ST_ADD;
            cnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ADD: begin
          // Sum enters at the MSB; after WIDTH shifts bit 0 sits at s_q[0].
          s_q   <= {sum_bit, s_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q <= 1'b0;
          cnt_q  <= '0;
          if (carry_q) begin
            ovf_q <= 1'b1;
          end
          if (SATURATE && carry_q) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            a_q     <= b_q;
            b_q     <= s_q;
            if (index_q != '1) begin
              index_q <= index_q + IDX_ONE;
            end
            valid_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_HALT: begin
          busy_q   <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign term      = b_q;
  assign index     = index_q;
  assign overflow  = ovf_q;
  assign halted    = halted_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fib_serial_gen.sv
// tb_fib_serial_gen: directed bench for fib_serial_gen with three instances:
//   u_wrap - WIDTH=16, SATURATE=0
//   u_sat  - WIDTH=16, SATURATE=1
//   u_w8   - WIDTH=8,  SATURATE=0
module tb_fib_serial_gen;
  import fib_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset   = 1'b0;
  logic [2:0] step_v  = 3'b000;
  logic [2:0] clear_v = 3'b000;

  logic        busy_a, valid_a, ovf_a, halt_a;
  logic        busy_b, valid_b, ovf_b, halt_b;
  logic        busy_c, valid_c, ovf_c, halt_c;
  logic [15:0] term_a, term_b;
  logic [7:0]  term_c;
  logic [7:0]  idx_a, idx_b, idx_c;
  logic [1:0]  st_a, st_b, st_c;

  fib_serial_gen #(.WIDTH(16), .SEED_A(0), .SEED_B(1), .IDXW(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear_v[0]), .step(step_v[0]),
    .busy(busy_a), .valid(valid_a), .term(term_a), .index(idx_a),
    .overflow(ovf_a), .halted(halt_a), .state_dbg(st_a)
  );

  fib_serial_gen #(.WIDTH(16), .SEED_A(0), .SEED_B(1), .IDXW(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear_v[1]), .step(step_v[1]),
    .busy(busy_b), .valid(valid_b), .term(term_b), .index(idx_b),
    .overflow(ovf_b), .halted(halt_b), .state_dbg(st_b)
  );

  fib_serial_gen #(.WIDTH(8), .SEED_A(0), .SEED_B(1), .IDXW(8), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .reset(reset), .clear(clear_v[2]), .step(step_v[2]),
    .busy(busy_c), .valid(valid_c), .term(term_c), .index(idx_c),
    .overflow(ovf_c), .halted(halt_c), .state_dbg(st_c)
  );

  // ---------------- observation helpers ----------------
  function automatic logic [31:0] o_term(input int sel);
    case (sel)
      0:       return 32'(term_a);
      1:       return 32'(term_b);
      default: return 32'(term_c);
    endcase
  endfunction

  function automatic logic [31:0] o_index(input int sel);
    case (sel)
      0:       return 32'(idx_a);
      1:       return 32'(idx_b);
      default: return 32'(idx_c);
    endcase
  endfunction

  function automatic logic [31:0] o_state(input int sel);
    case (sel)
      0:       return 32'(st_a);
      1:       return 32'(st_b);
      default: return 32'(st_c);
    endcase
  endfunction

  function automatic logic o_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic o_valid(input int sel);
    case (sel)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  function automatic logic o_ovf(input int sel);
    case (sel)
      0:       return ovf_a;
      1:       return ovf_b;
      default: return ovf_c;
    endcase
  endfunction

  function automatic logic o_halt(input int sel);
    case (sel)
      0:       return halt_a;
      1:       return halt_b;
      default: return halt_c;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Pulse step for one edge, check busy right after that edge, then wait for
  // valid. exp_lat=0 means no valid pulse may appear within the window.
  task automatic run_step(input int sel, input int exp_lat, input logic exp_busy,
                          input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    step_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    step_v[sel] = 1'b0;
    check({tag, "_busy"}, 32'(o_busy(sel)), 32'(exp_busy));
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (o_valid(sel)) lat = n;
    end
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  // Count valid pulses seen over a bounded window.
  task automatic count_valid(input int sel, input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk);
      #1;
      if (o_valid(sel)) cnt++;
    end
  endtask

  task automatic do_clear(input int sel);
    @(negedge clk);
    clear_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    clear_v[sel] = 1'b0;
  endtask

  task automatic load_fib16();
    exp_q = {16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34,
             16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987,
             16'd1597, 16'd2584, 16'd4181, 16'd6765, 16'd10946, 16'd17711,
             16'd28657, 16'd46368};
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] exp;
    int          vcnt;

    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int s = 0; s < 3; s++) begin
      check("rst_term",  o_term(s),  1);
      check("rst_index", o_index(s), 1);
      check("rst_busy",  32'(o_busy(s)),  0);
      check("rst_valid", 32'(o_valid(s)), 0);
      check("rst_ovf",   32'(o_ovf(s)),   0);
      check("rst_halt",  32'(o_halt(s)),  0);
      check("rst_state", o_state(s), 32'(ST_IDLE));
    end

    // Wrap instance: F2..F24, 17-cycle latency each.
    load_fib16();
    for (int k = 0; k < 23; k++) begin
      run_step(0, 17, 1'b1, "wrap_step");
      exp = exp_q.pop_front();
      check("wrap_term", o_term(0), 32'(exp));
    end
    check("wrap_idx24", o_index(0), 24);
    check("wrap_ovf0",  32'(o_ovf(0)), 0);

    run_step(0, 17, 1'b1, "wrap_ovf_step");
    check("wrap_term25", o_term(0), 9489);
    check("wrap_ovf1",   32'(o_ovf(0)), 1);
    check("wrap_idx25",  o_index(0), 25);
    run_step(0, 17, 1'b1, "wrap_next");
    check("wrap_term26", o_term(0), 55857);
    check("wrap_ovf_sticky", 32'(o_ovf(0)), 1);
    check("wrap_idx26",  o_index(0), 26);

    // Saturating instance: same run, then halt on the overflowing step.
    load_fib16();
    for (int k = 0; k < 23; k++) begin
      run_step(1, 17, 1'b1, "sat_step");
      exp = exp_q.pop_front();
      check("sat_term", o_term(1), 32'(exp));
    end
    run_step(1, 0, 1'b1, "sat_ovf_step");
    check("sat_hold_term", o_term(1), 46368);
    check("sat_hold_idx",  o_index(1), 24);
    check("sat_halted",    32'(o_halt(1)), 1);
    check("sat_ovf",       32'(o_ovf(1)), 1);
    check("sat_state",     o_state(1), 32'(ST_HALT));
    check("sat_busy0",     32'(o_busy(1)), 0);
    run_step(1, 0, 1'b0, "sat_ignored");
    check("sat_ign_term",  o_term(1), 46368);
    check("sat_ign_state", o_state(1), 32'(ST_HALT));
    do_clear(1);
    check("sat_clr_term",  o_term(1), 1);
    check("sat_clr_idx",   o_index(1), 1);
    check("sat_clr_halt",  32'(o_halt(1)), 0);
    check("sat_clr_ovf",   32'(o_ovf(1)), 0);
    check("sat_clr_state", o_state(1), 32'(ST_IDLE));

    // Dropped step during ADD, wrap instance restarted from seeds.
    do_clear(0);
    check("clr_ovf", 32'(o_ovf(0)), 0);
    run_step(0, 17, 1'b1, "pre1");
    run_step(0, 17, 1'b1, "pre2");
    check("pre2_term", o_term(0), 2);
    @(negedge clk);
    step_v[0] = 1'b1;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step_v[0] = 1'b1;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    count_valid(0, 40, vcnt);
    check("drop_valid_cnt", vcnt, 1);
    check("drop_term",  o_term(0), 3);
    check("drop_idx",   o_index(0), 4);
    check("drop_state", o_state(0), 32'(ST_IDLE));

    // Clear sampled at ADD cycle 8.
    @(negedge clk);
    step_v[0] = 1'b1;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    clear_v[0] = 1'b1;
    @(posedge clk);
    #1;
    clear_v[0] = 1'b0;
    check("midclr_term",  o_term(0), 1);
    check("midclr_idx",   o_index(0), 1);
    check("midclr_state", o_state(0), 32'(ST_IDLE));
    check("midclr_busy",  32'(o_busy(0)), 0);
    count_valid(0, 30, vcnt);
    check("midclr_novalid", vcnt, 0);
    run_step(0, 17, 1'b1, "after_clr");
    check("after_clr_term", o_term(0), 1);
    check("after_clr_idx",  o_index(0), 2);

    // clear together with step: clear wins.
    @(negedge clk);
    step_v[2]  = 1'b1;
    clear_v[2] = 1'b1;
    @(posedge clk);
    #1;
    step_v[2]  = 1'b0;
    clear_v[2] = 1'b0;
    check("clrstep_state", o_state(2), 32'(ST_IDLE));
    check("clrstep_busy",  32'(o_busy(2)), 0);
    count_valid(2, 20, vcnt);
    check("clrstep_novalid", vcnt, 0);

    // WIDTH=8: F2..F13, then wrap 377 -> 121.
    exp_q = {16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34,
             16'd55, 16'd89, 16'd144, 16'd233};
    for (int k = 0; k < 12; k++) begin
      run_step(2, 9, 1'b1, "w8_step");
      exp = exp_q.pop_front();
      check("w8_term", o_term(2), 32'(exp));
    end
    check("w8_idx13", o_index(2), 13);
    check("w8_ovf0",  32'(o_ovf(2)), 0);
    run_step(2, 9, 1'b1, "w8_wrap");
    check("w8_term_wrap", o_term(2), 121);
    check("w8_ovf1",      32'(o_ovf(2)), 1);
    check("w8_idx14",     o_index(2), 14);

    // Asynchronous reset in the middle of an ADD.
    @(negedge clk);
    step_v[0] = 1'b1;
    @(posedge clk);
    #1;
    step_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_term",  o_term(0), 1);
    check("arst_idx",   o_index(0), 1);
    check("arst_busy",  32'(o_busy(0)), 0);
    check("arst_state", o_state(0), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b1;
    count_valid(0, 30, vcnt);
    check("arst_novalid", vcnt, 0);
    run_step(0, 17, 1'b1, "arst_after");
    check("arst_after_term", o_term(0), 1);
    check("arst_after_idx",  o_index(0), 2);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fib_serial_gen.md
Name: fib_serial_gen

Overview:
- Parametrised bit-serial Fibonacci term generator. It is the successor to the fixed 16-bit ripple tile chain.
- Holds the previous and current terms (A, B). On each accepted step it computes A+B one bit per clock through a single full-adder cell, then shifts the pair.
- Adds over WIDTH bits, a step/valid handshake, a term index, a sticky overflow flag and a selectable wrap/saturate mode.
- term feeds the existing per-nibble 7-segment decoders; overflow replaces the old carry-to-DP output.

Parameters:
- WIDTH, 16, term width in bits (>=4, multiple of 4 for display).
- SEED_A, 0, reset/clear value of the previous term A.
- SEED_B, 1, reset/clear value of the current term B, shown on term.
- IDXW, 8, width of the index counter.
- SATURATE, 0, overflow handling: 0 = wrap modulo 2^WIDTH, 1 = hold last valid term and halt.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart to seeds; highest priority after reset.
- step  in  1  request the next term; sampled only in IDLE.
- busy  out  1  high while a term is being computed (ADD, DONE).
- valid  out  1  one-cycle pulse when term/index have just updated.
- term  out  WIDTH  current term B; stable except at the DONE edge.
- index  out  IDXW  sequence index of term; reset value 1 (F1).
- overflow  out  1  sticky: an addition produced carry-out.
- halted  out  1  SATURATE=1 only: overflow occurred, further steps refused.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, A=SEED_A, B=SEED_B, index=1.
  - busy=0, valid=0, overflow=0, halted=0, bit counter=0, carry=0.
- States: IDLE, ADD, DONE, HALT.
- IDLE:
  - step=1 -> ADD; bit counter=0, carry=0, sum shift register S cleared.
  - step=0 -> stay in IDLE.
- ADD (exactly WIDTH cycles):
  - Each cycle: s = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry).
  - S shifts right with s entering the MSB.
  - A and B rotate right by one internally. term must not glitch, so term is driven from a separate output copy of B, or A/B are read through the bit counter index rather than rotated.
  - When the counter reaches WIDTH-1 -> DONE.
- DONE (one cycle):
  - Final carry=1 sets overflow.
  - If SATURATE=1 and carry=1: A and B are unchanged, index is unchanged, valid=0, next state is HALT.
  - Otherwise: A<=B, B<=S (mod 2^WIDTH), index<=index+1 (saturating at all-ones), valid=1, next state is IDLE.
- HALT:
  - step is ignored; busy=0; halted=1.
  - Only clear or reset leaves HALT.
- Latency: step sampled at edge 0 -> valid high in cycle WIDTH+1. Minimum step-to-step period is WIDTH+2 cycles.
- step while busy or in HALT is dropped, not queued.
- clear in any state, including mid-ADD:
  - Next edge restores the reset values of A, B, index, overflow, halted, carry and counter.
  - state=IDLE; valid=0.
  - clear together with step: clear wins and step is dropped.
- reset mid-operation aborts immediately; no partial term ever reaches term.
- Arithmetic: unsigned; carry is the only overflow source; overflow is never cleared except by clear or reset.

Decomposition:
- Shared package fib_pkg:
  - state enum (IDLE, ADD, DONE, HALT), 2 bits.
  - localparam for the bit counter width, $clog2(WIDTH).
  - Default seed constants.
- One natural sub-module, fib_bit_cell:
  - Full adder plus carry flop with clear and async active-low reset.
  - Inputs a, b, carry_clr, en; outputs s, carry.
  - Successor to the per-bit tile.
- FSM, S register and index counter stay in fib_serial_gen.

Test Plan:
- Reset with defaults -> term=1, index=1, busy=0, overflow=0. Pulse step -> busy rises next cycle; valid at cycle 17; term=1, index=2.
- 23 consecutive steps -> term sequence 1,2,3,5,...,46368; final index=24; overflow=0; each step's valid exactly 17 cycles after acceptance.
- SATURATE=0, one more step after 46368 -> term=9489 (75025-65536), overflow=1, index=25. The next step gives term=55857 (46368+9489), with overflow still 1.
- SATURATE=1, same point -> term stays 46368, index=24, halted=1, valid never pulses. Further steps are ignored; clear -> term=1, index=1, halted=0, overflow=0.
- step asserted again during ADD, and clear asserted at cycle 8 of an ADD -> the extra step is dropped. After clear: term=SEED_B, state IDLE, no valid pulse. reset=0 mid-ADD gives the same result asynchronously.
- WIDTH=8, SEED_A=0, SEED_B=1 -> F13=233 is reached after 12 steps. The next step wraps to 121 (377-256) with overflow=1. Latency is 9 cycles.
